temperature_calculator: RTL and testbench

- Converts a raw sensor ADC sample into a temperature word: tempc = tc_base + ((tc_ref × adc_data) >> 2).
- tc_base is the environment base degree, tc_ref the system working-voltage reference, adc_data the sensor digital sample.
- Sits between the sensor ADC front end and downstream temperature consumers.
- Fully pipelined: accepts one sample per clock and produces a registered result.

---
 rtl/temperature_calculator_if.sv | 22 ++
 rtl/temperature_calculator.sv | 58 +++++
 tb/tb_temperature_calculator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/temperature_calculator_if.sv
// Sample/result bundle between the ADC front end, the temperature
// calculator and downstream temperature consumers.
interface temperature_calculator_if;
   logic        in_valid;
   logic [31:0] tc_base;
   logic [7:0]  tc_ref;
   logic [15:0] adc_data;
   logic [31:0] tempc;
   logic        out_valid;

   // Sample producer: drives the raw sample, receives the result.
   modport master (
      output in_valid, tc_base, tc_ref, adc_data,
      input  tempc, out_valid
   );

   // Calculator side.
   modport slave (
      input  in_valid, tc_base, tc_ref, adc_data,
      output tempc, out_valid
   );
endinterface

// File: rtl/temperature_calculator.sv
// Two-stage temperature calculator: tempc = tc_base + ((tc_ref * adc_data) >> 2).
// Stage 1 registers the exact 24-bit product and the base; stage 2 adds the
// scaled product to the base modulo 2^32. One sample per clock, no backpressure.
module temperature_calculator (
   input  logic                    clk,
   input  logic                    rst,
   temperature_calculator_if.slave bus
);

   logic [23:0] prod_q,      prod_d;
   logic [31:0] base_q,      base_d;
   logic        v1_q,        v1_d;
   logic [31:0] tempc_q,     tempc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] scaled;

   // Stage 1: capture the full product and base when a sample is offered.
   always_comb begin
      prod_d = prod_q;
      base_d = base_q;
      v1_d   = bus.in_valid;
      if (bus.in_valid) begin
         prod_d = {16'd0, bus.tc_ref} * {8'd0, bus.adc_data};
         base_d = bus.tc_base;
      end
   end

   // Stage 2: scale by 1/4 (fraction dropped), add base, hold between results.
   always_comb begin
      scaled      = {10'd0, prod_q[23:2]};
      tempc_d     = tempc_q;
      out_valid_d = v1_q;
      if (v1_q) begin
         tempc_d = base_q + scaled;
      end
   end

   // Pipeline registers; reset discards any in-flight sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_q      <= '0;
         base_q      <= '0;
         v1_q        <= 1'b0;
         tempc_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         prod_q      <= prod_d;
         base_q      <= base_d;
         v1_q        <= v1_d;
         tempc_q     <= tempc_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.tempc     = tempc_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_temperature_calculator.sv
// Scoreboard bench for temperature_calculator: the driver pushes hand-computed
// results tagged with the cycle they are due; the monitor compares on each
// falling edge, checking pulses, held values and reset behaviour.
module tb_temperature_calculator;

   typedef struct {
      logic [31:0] val;
      int          due;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   logic rst_at_edge;
   int   n_applied;
   int   n_miss;
   logic [31:0] last_exp;
   exp_t q[$];

   temperature_calculator_if bus_if ();

   temperature_calculator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   // Monitor: compares DUT output against the scoreboard every falling edge.
   initial begin
      exp_t e;
      n_applied = 0;
      n_miss    = 0;
      last_exp  = 32'd0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (rst_at_edge) begin
            last_exp = 32'd0;
            n_applied++;
            if (bus_if.out_valid !== 1'b0 || bus_if.tempc !== 32'd0) begin
               n_miss++;
               $display("FAIL reset_state: out_valid=%b tempc=%h, required out_valid=0 tempc=00000000",
                        bus_if.out_valid, bus_if.tempc);
            end
         end else if (bus_if.out_valid === 1'b1) begin
            n_applied++;
            if (q.size() == 0) begin
               n_miss++;
               $display("FAIL spurious_pulse: out_valid=1 tempc=%h at cycle %0d, required no pulse",
                        bus_if.tempc, cyc);
            end else begin
               e = q.pop_front();
               last_exp = e.val;
               if (e.due != cyc || bus_if.tempc !== e.val) begin
                  n_miss++;
                  $display("FAIL result: tempc=%h at cycle %0d, required %h at cycle %0d",
                           bus_if.tempc, cyc, e.val, e.due);
               end
            end
         end else begin
            n_applied++;
            if (q.size() != 0 && q[0].due <= cyc) begin
               e = q.pop_front();
               n_miss++;
               $display("FAIL missing_pulse: out_valid=%b at cycle %0d, required pulse with tempc=%h",
                        bus_if.out_valid, cyc, e.val);
            end else if (bus_if.out_valid !== 1'b0 || bus_if.tempc !== last_exp) begin
               n_miss++;
               $display("FAIL hold: out_valid=%b tempc=%h, required out_valid=0 tempc=%h",
                        bus_if.out_valid, bus_if.tempc, last_exp);
            end
         end
      end
   end

   // Present one input vector for the next rising edge.
   task automatic drive(input logic r, input logic v, input logic [31:0] base,
                        input logic [7:0] tref, input logic [15:0] adc,
                        input logic [31:0] expv);
      exp_t e;
      @(posedge clk);
      #1;
      rst             = r;
      bus_if.in_valid = v;
      bus_if.tc_base  = base;
      bus_if.tc_ref   = tref;
      bus_if.adc_data = adc;
      if (r) begin
         while (q.size() != 0 && q[$].due >= cyc + 1) void'(q.pop_back());
      end else if (v) begin
         e.val = expv;
         e.due = cyc + 2;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, 8'($urandom), 16'($urandom), 32'd0);
   endtask

   initial begin
      int budget;
      rst             = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.tc_base  = 32'h1234_5678;
      bus_if.tc_ref   = 8'h5A;
      bus_if.adc_data = 16'hBEEF;

      // Reset held with valid, random samples: nothing may emerge.
      drive(1'b1, 1'b1, $urandom, 8'($urandom), 16'($urandom), 32'd0);
      drive(1'b1, 1'b1, $urandom, 8'($urandom), 16'($urandom), 32'd0);
      idle(3);

      // Basic, then hold.
      drive(1'b0, 1'b1, 32'd1, 8'd4, 16'd4, 32'd5);
      idle(4);

      // Mixed pattern.
      drive(1'b0, 1'b1, 32'hAAAA_AAAA, 8'hC6, 16'hAAAA, 32'hAACB_AA89);
      idle(3);

      // Maximum product with fraction dropped; then small truncation to zero.
      drive(1'b0, 1'b1, 32'd0, 8'hFF, 16'hFFFF, 32'h003F_BFC0);
      idle(2);
      drive(1'b0, 1'b1, 32'd0, 8'd1, 16'd3, 32'd0);
      idle(3);

      // Wrap-around.
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 8'd4, 16'd4, 32'd3);
      idle(3);

      // Streaming back-to-back.
      drive(1'b0, 1'b1, 32'd1, 8'd4, 16'd4, 32'd5);
      drive(1'b0, 1'b1, 32'hAAAA_AAAA, 8'hC6, 16'hAAAA, 32'hAACB_AA89);
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 8'd4, 16'd4, 32'd3);
      idle(4);

      // Streaming with reset one edge after the second sample.
      drive(1'b0, 1'b1, 32'd1, 8'd4, 16'd4, 32'd5);
      drive(1'b0, 1'b1, 32'hAAAA_AAAA, 8'hC6, 16'hAAAA, 32'hAACB_AA89);
      drive(1'b1, 1'b1, 32'hFFFF_FFFF, 8'd4, 16'd4, 32'd3);
      idle(5);

      // Mixed pattern after reset release.
      drive(1'b0, 1'b1, 32'hAAAA_AAAA, 8'hC6, 16'hAAAA, 32'hAACB_AA89);
      idle(2);

      budget = 20;
      while (q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_applied++;
         n_miss++;
         $display("FAIL drain: %0d results outstanding, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule
